booth_sequencer: RTL and testbench

//  FSM controller that sequences the radix-2 Booth multiplier datapath (A/S/P registers, adder, shifter).

---
 rtl/booth_pkg.sv | 33 +++
 rtl/iter_counter.sv | 47 ++++
 rtl/booth_sequencer.sv | 117 +++++++++++
 tb/tb_booth_sequencer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types for the radix-2 Booth multiplier sequencer.
//   booth_state_t : controller states
//   booth_op_t    : datapath operation selected by the Booth pair bits
//   booth_decode  : maps {P[0], appended bit} to the add/sub/none operation
package booth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EVAL,
    SHIFT,
    DONE
  } booth_state_t;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_ADD,
    OP_SUB
  } booth_op_t;

  // 01 ends a run of ones (add multiplicand), 10 starts one (subtract),
  // 00 and 11 sit inside a run and need no arithmetic.
  function automatic booth_op_t booth_decode(input logic [1:0] pair);
    booth_op_t op;
    case (pair)
      2'b01:   op = OP_ADD;
      2'b10:   op = OP_SUB;
      default: op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/iter_counter.sv
// Booth iteration counter.
//   clk   : clock
//   reset : synchronous active-high reset, clears the count
//   clr   : synchronous clear (wins over inc)
//   inc   : advance by one; saturates at WORD_LENGTH-1
//   iter  : completed-iteration count
//   last  : high while the count equals WORD_LENGTH-1
module iter_counter #(
  parameter  int WORD_LENGTH = 16,
  localparam int CNT_W       = $clog2(WORD_LENGTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] iter,
  output logic             last
);

  logic [CNT_W-1:0] iter_d;
  logic [CNT_W-1:0] iter_q;

  assign last = (iter_q == CNT_W'(WORD_LENGTH - 1));
  assign iter = iter_q;

  // NOTE: every always_comb target gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    iter_d = iter_q;
    if (clr) begin
      iter_d = '0;
    end else if (inc && !last) begin
      iter_d = iter_q + CNT_W'(1);
    end
  end

  // NOTE: flops use non-blocking assignments so every register samples the
  // pre-edge values of the others; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (reset) begin
      iter_q <= '0;
    end else begin
      iter_q <= iter_d;
    end
  end

endmodule

// File: rtl/booth_sequencer.sv
// Controller for a radix-2 Booth multiplier datapath (A/S/P registers, adder,
// shifter). One load, WORD_LENGTH evaluate/shift pairs, then a result strobe.
//   clk, reset : clock, synchronous active-high reset
//   start      : request a multiply (accepted in IDLE and DONE)
//   abort      : cancel a run in progress; beats start
//   booth_pair : P[1:0] from the datapath, looked at only in EVAL
//   ld_en      : load A/S/P initial values
//   add_en     : P <= P + A
//   sub_en     : P <= P + S
//   shift_en   : arithmetic right shift of P
//   res_we     : capture product into result register
//   busy       : run in progress (LOAD/EVAL/SHIFT)
//   ready      : one-cycle product-valid pulse
//   iter       : completed-iteration count
module booth_sequencer
  import booth_pkg::*;
#(
  parameter  int WORD_LENGTH = 16,
  localparam int CNT_W       = $clog2(WORD_LENGTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       booth_pair,
  output logic             ld_en,
  output logic             add_en,
  output logic             sub_en,
  output logic             shift_en,
  output logic             res_we,
  output logic             busy,
  output logic             ready,
  output logic [CNT_W-1:0] iter
);

  booth_state_t state_d;
  booth_state_t state_q;
  booth_op_t    op;
  logic         iter_last;
  logic         iter_clr;
  logic         iter_inc;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && !abort) state_d = LOAD;
      LOAD:    state_d = abort ? IDLE : EVAL;
      EVAL:    state_d = abort ? IDLE : SHIFT;
      SHIFT: begin
        if (abort)          state_d = IDLE;
        else if (iter_last) state_d = DONE;
        else                state_d = EVAL;
      end
      // ready/res_we still fire this cycle even if abort is high.
      DONE:    state_d = (start && !abort) ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Clearing on the way into IDLE makes iter read 0 in every IDLE cycle,
  // including straight after an abort or a finished run. In DONE->LOAD the
  // count holds through LOAD and clears for the first EVAL.
  assign iter_clr = (state_q == LOAD) || (state_d == IDLE);
  assign iter_inc = (state_q == SHIFT);

  iter_counter #(
    .WORD_LENGTH(WORD_LENGTH)
  ) u_iter_counter (
    .clk  (clk),
    .reset(reset),
    .clr  (iter_clr),
    .inc  (iter_inc),
    .iter (iter),
    .last (iter_last)
  );

  assign op = booth_decode(booth_pair);

  always_comb begin
    ld_en    = 1'b0;
    add_en   = 1'b0;
    sub_en   = 1'b0;
    shift_en = 1'b0;
    res_we   = 1'b0;
    busy     = 1'b0;
    ready    = 1'b0;
    case (state_q)
      LOAD: begin
        ld_en = 1'b1;
        busy  = 1'b1;
      end
      EVAL: begin
        busy   = 1'b1;
        add_en = (op == OP_ADD);
        sub_en = (op == OP_SUB);
      end
      SHIFT: begin
        busy     = 1'b1;
        shift_en = 1'b1;
      end
      DONE: begin
        ready  = 1'b1;
        res_we = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_booth_sequencer.sv
// Self-checking bench: a 16-bit and a 4-bit sequencer share the same stimulus
// and are compared every cycle against a timeline model of the operation.
module tb_booth_sequencer;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] pair  = 2'b00;

  logic       ld16, add16, sub16, sh16, we16, busy16, rdy16;
  logic [4:0] it16;
  logic       ld4, add4, sub4, sh4, we4, busy4, rdy4;
  logic [2:0] it4;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int base   = 0;

  // Model state: t = cycles since LOAD (-1 when idle), pit = last expected iter.
  int t16  = -1;
  int t4   = -1;
  int pit16 = 0;
  int pit4  = 0;
  int rq16[$];
  int rq4[$];

  always #5 clk = ~clk;

  booth_sequencer #(.WORD_LENGTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .booth_pair(pair),
    .ld_en(ld16), .add_en(add16), .sub_en(sub16), .shift_en(sh16),
    .res_we(we16), .busy(busy16), .ready(rdy16), .iter(it16)
  );

  booth_sequencer #(.WORD_LENGTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .booth_pair(pair),
    .ld_en(ld4), .add_en(add4), .sub_en(sub4), .shift_en(sh4),
    .res_we(we4), .busy(busy4), .ready(rdy4), .iter(it4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Operation timeline: t=0 LOAD, odd t in 1..2w evaluate, even t in 2..2w
  // shift, t=2w+1 result. Returns {ld,add,sub,shift,res_we,busy,ready}.
  function automatic logic [6:0] exp_vec(input int w, input int t, input logic [1:0] pr);
    logic ev, sh, dn;
    ev = (t >= 1) && (t <= 2 * w) && (t % 2 == 1);
    sh = (t >= 2) && (t <= 2 * w) && (t % 2 == 0);
    dn = (t == 2 * w + 1);
    return {t == 0, ev && pr == 2'b01, ev && pr == 2'b10, sh, dn,
            (t >= 0) && (t <= 2 * w), dn};
  endfunction

  function automatic int exp_iter(input int w, input int t, input int prev);
    if (t >= 1 && t <= 2 * w) return (t - 1) / 2;
    if (t == 2 * w + 1)       return w - 1;
    if (t == 0)               return prev;
    return 0;
  endfunction

  function automatic int next_t(input int w, input int t, input logic rs,
                                input logic st, input logic ab);
    if (rs)            return -1;
    if (t < 0)         return (st && !ab) ? 0 : -1;
    if (t == 2 * w + 1) return (!ab && st) ? 0 : -1;
    return ab ? -1 : t + 1;
  endfunction

  task automatic step(input logic rs, input logic st, input logic ab, input logic [1:0] pr);
    int ei16, ei4;
    @(negedge clk);
    reset = rs;
    start = st;
    abort = ab;
    pair  = pr;
    #1;
    ei16 = exp_iter(16, t16, pit16);
    ei4  = exp_iter(4, t4, pit4);
    check($sformatf("c%0d w16 ctl", cyc),
          {25'd0, ld16, add16, sub16, sh16, we16, busy16, rdy16},
          {25'd0, exp_vec(16, t16, pr)});
    check($sformatf("c%0d w16 iter", cyc), 32'(it16), 32'(ei16));
    check($sformatf("c%0d w4 ctl", cyc),
          {25'd0, ld4, add4, sub4, sh4, we4, busy4, rdy4},
          {25'd0, exp_vec(4, t4, pr)});
    check($sformatf("c%0d w4 iter", cyc), 32'(it4), 32'(ei4));
    if (rdy16 === 1'b1) rq16.push_back(cyc - base);
    if (rdy4 === 1'b1)  rq4.push_back(cyc - base);
    pit16 = ei16;
    pit4  = ei4;
    t16   = next_t(16, t16, rs, st, ab);
    t4    = next_t(4, t4, rs, st, ab);
    cyc++;
  endtask

  task automatic begin_test();
    base = cyc;
    rq16.delete();
    rq4.delete();
  endtask

  initial begin
    logic b;
    repeat (2) @(posedge clk);

    // Basic run, pair=01 held: ready at 34 (w16) and 10 (w4).
    begin_test();
    for (int i = 0; i < 38; i++) step(1'b0, i == 0, 1'b0, 2'b01);
    check("t2 ready16 count", rq16.size(), 1);
    check("t2 ready16 cycle", rq16[0], 34);
    check("t2 ready4 count", rq4.size(), 1);
    check("t2 ready4 cycle", rq4[0], 10);

    // pair=10 then pair in {00,11}.
    begin_test();
    for (int i = 0; i < 38; i++) step(1'b0, i == 0, 1'b0, 2'b10);
    check("t3 ready16 cycle", rq16[0], 34);
    for (int i = 0; i < 38; i++) begin
      b = 1'($urandom);
      step(1'b0, i == 0, 1'b0, {b, b});
    end

    // Back-to-back: start again during DONE.
    begin_test();
    for (int i = 0; i < 72; i++) step(1'b0, i == 0 || i == 34, 1'b0, 2'($urandom));
    check("t4 ready16 count", rq16.size(), 2);
    check("t4 ready16 second", rq16[1], 68);

    // Abort at 10, start at 5 while busy.
    begin_test();
    for (int i = 0; i < 42; i++) step(1'b0, i == 0 || i == 5, i == 10, 2'($urandom));
    check("t5 ready16 none", rq16.size(), 0);
    check("t5 ready4 count", rq4.size(), 1);
    check("t5 ready4 cycle", rq4[0], 10);

    // Reset held two cycles mid-run.
    begin_test();
    for (int i = 0; i < 20; i++) step(i == 10 || i == 11, i == 0, 1'b0, 2'($urandom));
    check("t1 ready16 none", rq16.size(), 0);

    // Random mix of start, abort, reset and pair values.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 39) == 0, 2'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
